// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - single-word RAM responder with fixed access latency
// Optional RAM_DROP_CNT_EN adds drop_cnt, counting requests that arrive while busy.
module ram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ack,
`ifdef RAM_DROP_CNT_EN
  output logic [7:0]  drop_cnt,
`endif
  output logic        stall
);

  localparam int         DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state, state_n;
  logic [3:0]              cnt, cnt_n;
  logic                    accept, complete;
  logic                    lat_we;
  logic [ADDR_WIDTH-1:0]   lat_idx;
  logic [31:0]             lat_din;
  logic [31:0]             dout_r;
  logic [31:0]             mem [DEPTH];

  // Byte offset and bits above the memory depth alias away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    accept   = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (cs) begin
          accept  = 1'b1;
          state_n = BUSY;
          cnt_n   = LAT_M1;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          complete = 1'b1;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we  <= 1'b0;
      lat_idx <= '0;
      lat_din <= 32'd0;
    end else if (accept) begin
      lat_we  <= we;
      lat_idx <= addr[ADDR_WIDTH+1:2];
      lat_din <= din;
    end
  end

  // Kept free of reset so the array maps onto block RAM; rst only vetoes the commit.
  always_ff @(posedge clk) begin
    if (!rst && complete && lat_we) begin
      mem[lat_idx] <= lat_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r <= 32'd0;
    end else if (complete && !lat_we) begin
      dout_r <= mem[lat_idx];
    end
  end

`ifdef RAM_DROP_CNT_EN
  logic [7:0] drop_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_r <= 8'd0;
    end else if (state == BUSY && cs && drop_r != 8'hFF) begin
      drop_r <= drop_r + 8'd1;
    end
  end

  assign drop_cnt = drop_r;
`endif

  assign ack   = (state == IDLE);
  assign stall = (state != IDLE);
  assign dout  = dout_r;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - randomized self-checking bench for ram_responder
// Set RAM_DROP_CNT_EN to also check drop_cnt.
module tb_ram_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        ack;
  logic        stall;
`ifdef RAM_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  ram_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .ack      (ack),
`ifdef RAM_DROP_CNT_EN
    .drop_cnt (drop_cnt),
`endif
    .stall    (stall)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit checking = 1'b0;

  // Reference: remaining busy cycles plus a flat word array.
  logic [31:0] mem_m [1024];
  int          m_left = 0;
  bit          m_we = 1'b0;
  int          m_idx = 0;
  logic [31:0] m_din = 32'd0;
  logic [31:0] m_dout = 32'd0;
  int          m_drop = 0;

  initial begin
    for (int i = 0; i < 1024; i++) mem_m[i] = 32'd0;
  end

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_left = 0;
      m_dout = 32'd0;
      m_drop = 0;
    end else if (m_left > 0) begin
      if (cs && m_drop < 255) m_drop++;
      m_left--;
      if (m_left == 0) begin
        if (m_we) mem_m[m_idx] = m_din;
        else m_dout = mem_m[m_idx];
      end
    end else if (cs) begin
      m_we   = we;
      m_idx  = int'(addr[11:2]);
      m_din  = din;
      m_left = LAT;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      if (ack !== (m_left == 0)) begin
        miscompares++;
        $display("FAIL ack cyc=%0d got=%b want=%b", cyc, ack, (m_left == 0));
      end
      if (stall !== (m_left != 0)) begin
        miscompares++;
        $display("FAIL stall cyc=%0d got=%b want=%b", cyc, stall, (m_left != 0));
      end
      if (dout !== m_dout) begin
        miscompares++;
        $display("FAIL dout cyc=%0d got=%h want=%h", cyc, dout, m_dout);
      end
`ifdef RAM_DROP_CNT_EN
      if (drop_cnt !== 8'(m_drop)) begin
        miscompares++;
        $display("FAIL drop_cnt cyc=%0d got=%0d want=%0d", cyc, drop_cnt, m_drop);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic wait_ack();
    int n = 0;
    while (ack !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (ack !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_timeout got=%b want=1", ack);
    end
  endtask

  // Returns #1 after the acceptance edge; acc_cyc is that edge's cycle number.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, output int acc_cyc);
    wait_ack();
    cs   = 1'b1;
    we   = w;
    addr = a;
    din  = d;
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    cs = 1'b0;
  endtask

  initial begin
    int t, first, last;
    logic [31:0] rd;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;
    chk("reset_ack", 32'(ack), 32'd1);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_dout", dout, 32'd0);

    issue(1'b1, 32'h10, 32'hDEADBEEF, t);
    chk("wr_ack_t1", 32'(ack), 32'd0);
    @(posedge clk); #1;
    chk("wr_ack_t2", 32'(ack), 32'd0);
    @(posedge clk); #1;
    chk("wr_ack_t3", 32'(ack), 32'd0);
    @(posedge clk); #1;
    chk("wr_ack_t4", 32'(ack), 32'd1);
    issue(1'b0, 32'h10, 32'd0, t);
    wait_ack();
    chk("rd_deadbeef", dout, 32'hDEADBEEF);

    issue(1'b1, 32'h20, 32'd1, first);
    issue(1'b1, 32'h24, 32'd2, t);
    issue(1'b1, 32'h28, 32'd3, t);
    issue(1'b1, 32'h2C, 32'd4, t);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'h20 + 32'(4 * i), 32'd0, last);
      wait_ack();
      chk("burst_rd", dout, 32'(i + 1));
    end
    chk("burst_span", 32'(last - first), 32'd28);

    issue(1'b0, 32'h20, 32'd0, t);
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b1; addr = 32'h20; din = 32'h55;
    @(posedge clk); #1;
    cs = 1'b0;
    wait_ack();
    chk("busy_ignored", dout, 32'd1);
`ifdef RAM_DROP_CNT_EN
    chk("drop_one", 32'(drop_cnt), 32'd1);
`endif
    issue(1'b0, 32'h20, 32'd0, t);
    wait_ack();
    chk("busy_no_write", dout, 32'd1);

    issue(1'b1, 32'h1000, 32'hA5A5A5A5, t);
    issue(1'b0, 32'h0000, 32'd0, t);
    wait_ack();
    chk("alias_rd", dout, 32'hA5A5A5A5);

    issue(1'b1, 32'h30, 32'h12345678, t);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_ack", 32'(ack), 32'd1);
    chk("rst_dout", dout, 32'd0);
    issue(1'b0, 32'h30, 32'd0, t);
    wait_ack();
    chk("rst_abort_wr", dout, 32'd0);

    // Random traffic: busy-time requests, aliased and misaligned addresses, sporadic reset.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst  = ($urandom_range(0, 99) == 0);
      cs   = ($urandom_range(0, 2) != 0);
      we   = $urandom_range(0, 1) == 1;
      addr = {$urandom_range(0, 1048575), 2'b00, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      din  = $urandom;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cs  = 1'b0;
    wait_ack();

    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 32'(i * 4), 32'd0, t);
      wait_ack();
      rd = mem_m[i];
      chk("final_rd", dout, rd);
    end

    repeat (2) @(posedge clk);
    #1;
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
